// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module  : fifo_stream_reader
// Purpose : Drains a fifo_v2 read port (empty/data/pop) into a valid/ready
//           stream through a 2-entry buffer that decouples ready_i from pop_o.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int  DATA_WIDTH = 32,
    parameter type dtype      = logic [DATA_WIDTH-1:0]
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       fifo_empty_i,
    input  dtype       fifo_data_i,
    output logic       fifo_pop_o,
    output logic       valid_o,
    input  logic       ready_i,
    output dtype       data_o,
    output logic [1:0] occupancy_o
);

    localparam logic [1:0] C_FULL = 2'd2;

    dtype       mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q,  count_d;

    logic       w_push;
    logic       w_out;

    // Pop decision uses only registered state, so ready_i never reaches pop_o.
    assign fifo_pop_o  = rst_ni & ~flush_i & ~fifo_empty_i & (count_q != C_FULL);
    assign w_push      = fifo_pop_o;
    assign valid_o     = (count_q != 2'd0);
    assign w_out       = valid_o & ready_i;
    assign data_o      = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (w_out) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_push, w_out})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so data_o reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (w_push) begin
            mem_q[wr_ptr_q] <= fifo_data_i;
        end
    end

endmodule

`default_nettype wire
